// File: rtl/bytebasher_pkg.sv
// Shared encodings and helpers for the whack-a-mole round sequencer.
package bytebasher_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ARM       = 3'd1,
      ST_WAIT      = 3'd2,
      ST_HIT       = 3'd3,
      ST_MISS      = 3'd4,
      ST_COOLDOWN  = 3'd5,
      ST_GAME_OVER = 3'd6
   } state_e;

   localparam logic [2:0] NO_BOX    = 3'd0;
   localparam logic [7:0] LFSR_SEED = 8'hA5;
   // Taps 8,6,5,4 of the Fibonacci LFSR, as a bit mask over lfsr[7:0].
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
      return {cur[6:0], ^(cur & LFSR_TAPS)};
   endfunction

   // Never returns NO_BOX and never repeats the previous round's box.
   function automatic logic [2:0] pick_target(input logic [7:0] lfsr, input logic [2:0] prev);
      logic [2:0] cand;
      cand = (lfsr[2:0] == NO_BOX) ? 3'd1 : lfsr[2:0];
      if (cand == prev) begin
         cand = (prev == 3'd7) ? 3'd1 : prev + 3'd1;
      end
      return cand;
   endfunction

endpackage

// File: rtl/hit_controller_if.sv
// Game-side signal bundle of the hit controller: sensor/start inputs and LED/HEX outputs.
interface hit_controller_if;
   logic       start;
   logic [2:0] box_address;
   logic [2:0] target_box;
   logic       hit_pulse;
   logic       miss_pulse;
   logic [6:0] score;
   logic [1:0] lives;
   logic       game_over;
   logic [2:0] state_dbg;

   modport master (
      output start, box_address,
      input  target_box, hit_pulse, miss_pulse, score, lives, game_over, state_dbg
   );

   modport slave (
      input  start, box_address,
      output target_box, hit_pulse, miss_pulse, score, lives, game_over, state_dbg
   );
endinterface

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser and stability debouncer for the box sensor address,
// plus a one-cycle strike strobe when the accepted value leaves NO_BOX.
module sensor_debounce
   import bytebasher_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [2:0] box_address_i,
   output logic [2:0] box_stable_o,
   output logic       strike_o
);
   localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 2);

   logic [2:0]    s1_q, s2_q, s2_last_q;
   logic [2:0]    stable_q, stable_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          strike_q, strike_d;

   always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      if ((s2_q != stable_q) && (s2_q == s2_last_q)) begin
         // Counter would reach DEBOUNCE_CYCLES-1 on this edge: accept instead.
         if (cnt_q == CNT_LAST) begin
            stable_d = s2_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
      strike_d = (stable_d != NO_BOX) && (stable_q == NO_BOX);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_q      <= NO_BOX;
         s2_q      <= NO_BOX;
         s2_last_q <= NO_BOX;
         stable_q  <= NO_BOX;
         cnt_q     <= '0;
         strike_q  <= 1'b0;
      end else begin
         s1_q      <= box_address_i;
         s2_q      <= s1_q;
         s2_last_q <= s2_q;
         stable_q  <= stable_d;
         cnt_q     <= cnt_d;
         strike_q  <= strike_d;
      end
   end

   assign box_stable_o = stable_q;
   assign strike_o     = strike_q;
endmodule

// File: rtl/hit_controller.sv
// Whack-a-mole round sequencer: picks a target, times the round, classifies
// strikes and keeps score and lives.
//
// state     | meaning
// IDLE      | no game running, waiting for start
// ARM       | pick next target and load round timer (1 cycle)
// WAIT      | target lit, waiting for a strike or timeout
// HIT       | correct strike, hit_pulse, score update (1 cycle)
// MISS      | wrong strike or timeout, miss_pulse, lose a life (1 cycle)
// COOLDOWN  | wait for the sensor to return to no box
// GAME_OVER | lives exhausted, score held, waiting for start
module hit_controller
   import bytebasher_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int ROUND_CYCLES    = 50000000,
   parameter int LIVES_INIT      = 3,
   parameter int SCORE_MAX       = 99
) (
   input logic             CLOCK_50,
   input logic             Reset,
   hit_controller_if.slave bus
);
   localparam int TW = (ROUND_CYCLES > 1) ? $clog2(ROUND_CYCLES) : 1;
   localparam logic [TW-1:0] TIMER_LOAD = TW'(ROUND_CYCLES - 1);
   localparam logic [1:0]    LIVES_LOAD = 2'(LIVES_INIT);
   localparam logic [6:0]    SCORE_TOP  = 7'(SCORE_MAX);

   state_e        state_q, state_d;
   logic [2:0]    target_q, target_d;
   logic [2:0]    prev_target_q, prev_target_d;
   logic [6:0]    score_q, score_d;
   logic [1:0]    lives_q, lives_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [7:0]    lfsr_q;
   logic [2:0]    box_stable;
   logic          strike;
   logic [2:0]    cand;

   sensor_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk_i        (CLOCK_50),
      .rst_i        (Reset),
      .box_address_i(bus.box_address),
      .box_stable_o (box_stable),
      .strike_o     (strike)
   );

   assign cand = pick_target(lfsr_q, prev_target_q);

   always_comb begin
      state_d       = state_q;
      target_d      = target_q;
      prev_target_d = prev_target_q;
      score_d       = score_q;
      lives_d       = lives_q;
      timer_d       = timer_q;
      case (state_q)
         ST_IDLE, ST_GAME_OVER: begin
            target_d = NO_BOX;
            if (bus.start) begin
               score_d = '0;
               lives_d = LIVES_LOAD;
               state_d = ST_ARM;
            end
         end
         ST_ARM: begin
            target_d      = cand;
            prev_target_d = cand;
            timer_d       = TIMER_LOAD;
            state_d       = ST_WAIT;
         end
         ST_WAIT: begin
            // A strike takes priority over an expiring timer.
            if (strike) begin
               state_d = (box_stable == target_q) ? ST_HIT : ST_MISS;
            end else if (timer_q == '0) begin
               state_d = ST_MISS;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         ST_HIT: begin
            score_d  = (score_q >= SCORE_TOP) ? SCORE_TOP : score_q + 7'd1;
            target_d = NO_BOX;
            state_d  = ST_COOLDOWN;
         end
         ST_MISS: begin
            target_d = NO_BOX;
            if (lives_q <= 2'd1) begin
               lives_d = 2'd0;
               state_d = ST_GAME_OVER;
            end else begin
               lives_d = lives_q - 2'd1;
               state_d = ST_COOLDOWN;
            end
         end
         ST_COOLDOWN: begin
            if (box_stable == NO_BOX) begin
               state_d = ST_ARM;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (Reset) begin
         state_q       <= ST_IDLE;
         target_q      <= NO_BOX;
         prev_target_q <= NO_BOX;
         score_q       <= '0;
         lives_q       <= LIVES_LOAD;
         timer_q       <= '0;
         lfsr_q        <= LFSR_SEED;
      end else begin
         state_q       <= state_d;
         target_q      <= target_d;
         prev_target_q <= prev_target_d;
         score_q       <= score_d;
         lives_q       <= lives_d;
         timer_q       <= timer_d;
         lfsr_q        <= lfsr_step(lfsr_q);
      end
   end

   assign bus.target_box = target_q;
   assign bus.hit_pulse  = (state_q == ST_HIT);
   assign bus.miss_pulse = (state_q == ST_MISS);
   assign bus.score      = score_q;
   assign bus.lives      = lives_q;
   assign bus.game_over  = (state_q == ST_GAME_OVER);
   assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_hit_controller.sv
// Scoreboard bench for hit_controller: stimulus queues expected outcomes,
// a forked monitor pops them on each hit/miss pulse and checks target picks.
module tb_hit_controller;

   typedef struct {
      logic       is_hit;
      logic [6:0] score;
      logic [1:0] lives;
      logic       go;
   } exp_t;

   logic CLOCK_50 = 1'b0;
   logic Reset    = 1'b1;

   hit_controller_if bus();

   hit_controller #(
      .DEBOUNCE_CYCLES(4),
      .ROUND_CYCLES   (20),
      .LIVES_INIT     (3),
      .SCORE_MAX      (99)
   ) dut (
      .CLOCK_50(CLOCK_50),
      .Reset   (Reset),
      .bus     (bus)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   int         errors = 0;
   int         checks = 0;
   exp_t       exp_q[$];
   logic       mon_busy = 1'b0;
   logic [2:0] m_prev_tgt = 3'd0;
   logic [2:0] m_cur_tgt = 3'd0;
   logic [7:0] m_lfsr = 8'hA5;
   logic [7:0] m_lfsr_prev = 8'hA5;

   // Reference LFSR; m_lfsr_prev is the value the DUT saw at the last edge.
   always @(posedge CLOCK_50) begin
      m_lfsr_prev <= m_lfsr;
      if (Reset) m_lfsr <= 8'hA5;
      else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
   end

   function automatic logic [2:0] model_pick(input logic [7:0] l, input logic [2:0] p);
      logic [2:0] c;
      c = l[2:0];
      if (c == 3'd0) c = 3'd1;
      if (c == p) c = (p == 3'd7) ? 3'd1 : p + 3'd1;
      return c;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic expect_outcome(input logic hit, input logic [6:0] s,
                                 input logic [1:0] l, input logic go);
      exp_t e;
      e.is_hit = hit;
      e.score  = s;
      e.lives  = l;
      e.go     = go;
      exp_q.push_back(e);
   endtask

   task automatic run_monitor();
      exp_t       e;
      exp_t       post_e;
      logic [2:0] last_tgt;
      logic [2:0] cand;
      last_tgt = 3'd0;
      post_e.is_hit = 1'b0; post_e.score = '0; post_e.lives = '0; post_e.go = 1'b0;
      forever begin
         @(negedge CLOCK_50);
         if (mon_busy) begin
            check("post_score", int'(bus.score), int'(post_e.score));
            check("post_lives", int'(bus.lives), int'(post_e.lives));
            check("post_game_over", int'(bus.game_over), int'(post_e.go));
            check("post_target_cleared", int'(bus.target_box), 0);
            mon_busy = 1'b0;
         end
         if (bus.hit_pulse || bus.miss_pulse) begin
            if (exp_q.size() == 0) begin
               check("unexpected_pulse", int'({bus.hit_pulse, bus.miss_pulse}), 0);
            end else begin
               e = exp_q.pop_front();
               check("pulse_kind", int'({bus.hit_pulse, bus.miss_pulse}),
                     e.is_hit ? 2 : 1);
               post_e   = e;
               mon_busy = 1'b1;
            end
         end
         if (bus.target_box != 3'd0 && last_tgt == 3'd0) begin
            cand = model_pick(m_lfsr_prev, m_prev_tgt);
            check("target_pick", int'(bus.target_box), int'(cand));
            m_prev_tgt = cand;
            m_cur_tgt  = cand;
         end
         last_tgt = bus.target_box;
         if (Reset) m_prev_tgt = 3'd0;
      end
   endtask

   task automatic wait_state(input logic [2:0] st, input int budget);
      int n;
      n = 0;
      while (bus.state_dbg != st && n < budget) begin
         tick();
         n++;
      end
      check("reach_state", int'(bus.state_dbg), int'(st));
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || mon_busy) && n < budget) begin
         tick();
         n++;
      end
      check("outcome_pending", exp_q.size() + int'(mon_busy), 0);
   endtask

   task automatic hit_round(input logic [6:0] s, input logic [1:0] l);
      wait_state(3'd2, 60);
      tick();
      expect_outcome(1'b1, s, l, 1'b0);
      bus.box_address = m_cur_tgt;
      repeat (8) tick();
      bus.box_address = 3'd0;
      wait_done(40);
   endtask

   task automatic timeout_round(input logic [6:0] s, input logic [1:0] l, input logic go);
      wait_state(3'd2, 60);
      expect_outcome(1'b0, s, l, go);
      wait_done(40);
   endtask

   initial begin
      int         n;
      logic [2:0] wrong;
      logic       pulses;
      bus.start       = 1'b0;
      bus.box_address = 3'd0;
      fork
         run_monitor();
      join_none

      // Reset; align start so ARM samples LFSR = A5 again (period 255).
      tick();
      tick();
      Reset = 1'b0;
      check("rst_state", int'(bus.state_dbg), 0);
      check("rst_target", int'(bus.target_box), 0);
      check("rst_lives", int'(bus.lives), 3);
      check("rst_score", int'(bus.score), 0);
      check("rst_pulses", int'({bus.hit_pulse, bus.miss_pulse, bus.game_over}), 0);
      repeat (254) tick();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check("start_arm", int'(bus.state_dbg), 1);
      tick();
      check("first_wait", int'(bus.state_dbg), 2);
      check("first_target", int'(bus.target_box), 5);
      check("first_lives", int'(bus.lives), 3);
      check("first_score", int'(bus.score), 0);

      // Correct strike on box 5; next target must differ.
      hit_round(7'd1, 2'd3);
      wait_state(3'd2, 60);
      check("new_target_differs", int'(bus.target_box != 3'd5 && bus.target_box != 3'd0), 1);

      // Short glitch plus an ignored start: round still times out after 20 cycles.
      expect_outcome(1'b0, 7'd1, 2'd2, 1'b0);
      n = 0;
      bus.box_address = 3'd3;
      tick(); n++;
      tick(); n++;
      bus.box_address = 3'd0;
      bus.start = 1'b1;
      tick(); n++;
      bus.start = 1'b0;
      while (!bus.miss_pulse && n < 40) begin
         tick();
         n++;
      end
      check("timeout_cycles", n, 20);
      wait_done(40);

      // Wrong box.
      wait_state(3'd2, 60);
      tick();
      wrong = (m_cur_tgt % 3'd7) + 3'd1;
      expect_outcome(1'b0, 7'd1, 2'd1, 1'b0);
      bus.box_address = wrong;
      repeat (8) tick();
      bus.box_address = 3'd0;
      wait_done(40);

      // Last life lost; score is held in GAME_OVER.
      timeout_round(7'd1, 2'd0, 1'b1);
      tick();
      check("go_state", int'(bus.state_dbg), 6);
      check("go_score_held", int'(bus.score), 1);

      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check("restart_state", int'(bus.state_dbg), 1);
      check("restart_lives", int'(bus.lives), 3);
      check("restart_score", int'(bus.score), 0);

      // Three consecutive timeouts.
      timeout_round(7'd0, 2'd2, 1'b0);
      timeout_round(7'd0, 2'd1, 1'b0);
      timeout_round(7'd0, 2'd0, 1'b1);
      tick();
      check("go2_state", int'(bus.state_dbg), 6);
      check("go2_game_over", int'(bus.game_over), 1);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check("restart2_state", int'(bus.state_dbg), 1);
      check("restart2_lives", int'(bus.lives), 3);
      check("restart2_score", int'(bus.score), 0);

      // Hits up to and past saturation at 99.
      for (int i = 1; i <= 100; i++) begin
         hit_round((i > 99) ? 7'd99 : 7'(i), 2'd3);
      end

      // Reset mid-round with the correct box held.
      wait_state(3'd2, 60);
      tick();
      bus.box_address = m_cur_tgt;
      repeat (4) tick();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      check("midrst_state", int'(bus.state_dbg), 0);
      check("midrst_target", int'(bus.target_box), 0);
      check("midrst_score", int'(bus.score), 0);
      check("midrst_lives", int'(bus.lives), 3);
      check("midrst_outs", int'({bus.hit_pulse, bus.miss_pulse, bus.game_over}), 0);
      pulses = 1'b0;
      for (int k = 0; k < 12; k++) begin
         tick();
         pulses = pulses | bus.hit_pulse | bus.miss_pulse;
      end
      bus.box_address = 3'd0;
      check("midrst_no_pulse", int'(pulses), 0);
      check("midrst_idle", int'(bus.state_dbg), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
